// File: rtl/l_instr_seq.sv
// +--------------------------------------------------------------------------+
// | l_instr_seq : handshaked logic unit, 1-cycle bitwise ops, iterative       |
// | shifts/rotates (one bit per clock), result held until consumed. Rev 1.0   |
// +--------------------------------------------------------------------------+
`default_nettype none

module l_instr_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           sel,
  input  logic [WIDTH-1:0]     op1,
  input  logic [WIDTH-1:0]     op2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   l_out,
  output logic                 zero,
  output logic                 err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_NOT  = 4'b0011;
  localparam logic [3:0] OP_NAND = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_XNOR = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_ROL  = 4'b1010;
  localparam logic [3:0] OP_ROR  = 4'b1011;

  logic [1:0]       state_q, state_d;
  logic [3:0]       sel_q, sel_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] bit_res;
  logic             bit_undef;
  logic             is_shift;
  logic [31:0]      op2_ext;
  logic [31:0]      amt;
  logic [WIDTH-1:0] step_res;

  // Single-cycle bitwise result straight from the command inputs.
  always_comb begin
    bit_res   = '0;
    bit_undef = 1'b0;
    case (sel)
      OP_AND:  bit_res = op1 & op2;
      OP_OR:   bit_res = op1 | op2;
      OP_XOR:  bit_res = op1 ^ op2;
      OP_NOT:  bit_res = ~op1;
      OP_NAND: bit_res = ~(op1 & op2);
      OP_NOR:  bit_res = ~(op1 | op2);
      OP_XNOR: bit_res = ~(op1 ^ op2);
      OP_SRL, OP_SLL, OP_SRA, OP_ROL, OP_ROR: bit_res = '0;
      default: bit_undef = 1'b1;
    endcase
  end

  // Shifts saturate at WIDTH; rotates wrap modulo WIDTH.
  always_comb begin
    is_shift = (sel == OP_SRL) || (sel == OP_SLL) || (sel == OP_SRA) ||
               (sel == OP_ROL) || (sel == OP_ROR);
    op2_ext  = 32'(op2);
    if ((sel == OP_ROL) || (sel == OP_ROR)) begin
      amt = op2_ext % 32'(WIDTH);
    end else if (op2_ext >= 32'(WIDTH)) begin
      amt = 32'(WIDTH);
    end else begin
      amt = op2_ext;
    end
  end

  always_comb begin
    step_res = work_q;
    case (sel_q)
      OP_SRL:  step_res = {1'b0, work_q[WIDTH-1:1]};
      OP_SLL:  step_res = {work_q[WIDTH-2:0], 1'b0};
      OP_SRA:  step_res = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      OP_ROL:  step_res = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
      OP_ROR:  step_res = {work_q[0], work_q[WIDTH-1:1]};
      default: step_res = work_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    zero_d  = zero_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sel_d = sel;
          if (is_shift) begin
            work_d  = op1;
            cnt_d   = CNT_W'(amt);
            state_d = ST_EXEC;
          end else begin
            res_d   = bit_res;
            zero_d  = (bit_res == '0);
            err_d   = bit_undef;
            state_d = ST_HOLD;
          end
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          res_d   = work_q;
          zero_d  = (work_q == '0);
          err_d   = 1'b0;
          state_d = ST_HOLD;
        end else begin
          work_d = step_res;
          cnt_d  = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_HOLD);
  assign l_out     = {{WIDTH{1'b0}}, res_q};
  assign zero      = zero_q;
  assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_l_instr_seq.sv
// +--------------------------------------------------------------------------+
// | tb_l_instr_seq : scoreboard bench for l_instr_seq (WIDTH=4). Rev 1.0      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_l_instr_seq;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b1;
  logic [3:0]       sel = 4'd0;
  logic [WIDTH-1:0] op1 = '0;
  logic [WIDTH-1:0] op2 = '0;
  logic             in_ready;
  logic             out_valid;
  logic [2*WIDTH-1:0] l_out;
  logic             zero;
  logic             err;

  l_instr_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .op1(op1), .op2(op2),
    .out_valid(out_valid), .out_ready(out_ready),
    .l_out(l_out), .zero(zero), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] lo;
    logic       z;
    logic       e;
    int         at;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: first cycle of a result checks latency; every valid cycle checks data.
  initial begin : monitor
    logic prev;
    exp_t cur;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (out_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          cur = sbq[0];
          if (!prev) chk("latency", 32'(cyc), 32'(cur.at));
          chk("l_out", 32'(l_out), 32'(cur.lo));
          chk("zero", 32'(zero), 32'(cur.z));
          chk("err", 32'(err), 32'(cur.e));
          if (out_ready) void'(sbq.pop_front());
        end
      end
      prev = out_valid;
    end
  end

  task automatic issue(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] lo, input logic z, input logic e,
                       input int lat, input bit push);
    int k;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'd0, 32'd1);
      return;
    end
    sel = s; op1 = a; op2 = b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    if (push) sbq.push_back('{lo, z, e, cyc + lat - 1});
    @(negedge clk);
    in_valid = 1'b0;
    sel = 4'($urandom); op1 = 4'($urandom); op2 = 4'($urandom);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((sbq.size() != 0 || out_valid) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (sbq.size() != 0) chk("drain_timeout", 32'(sbq.size()), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int k;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_l_out", 32'(l_out), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;

    //     sel      op1      op2      l_out  z     e     lat
    issue(4'b0000, 4'b1100, 4'b1010, 8'h08, 1'b0, 1'b0, 1, 1'b1); // and
    // in_ready must be high at the negedge after the HOLD->IDLE edge
    @(negedge clk); #2;
    chk("in_ready_after_hs", 32'(in_ready), 32'd1);
    issue(4'b1000, 4'b0011, 4'd2,    8'h0C, 1'b0, 1'b0, 4, 1'b1); // sll 2
    issue(4'b0111, 4'b0011, 4'd0,    8'h03, 1'b0, 1'b0, 2, 1'b1); // srl 0
    issue(4'b1001, 4'b1000, 4'd9,    8'h0F, 1'b0, 1'b0, 6, 1'b1); // sra sat
    issue(4'b0111, 4'b1000, 4'd7,    8'h00, 1'b1, 1'b0, 6, 1'b1); // srl sat
    issue(4'b1010, 4'b1001, 4'd5,    8'h03, 1'b0, 1'b0, 3, 1'b1); // rol n=1
    issue(4'b1011, 4'b1001, 4'd4,    8'h09, 1'b0, 1'b0, 2, 1'b1); // ror n=0
    issue(4'b1110, 4'b1111, 4'b0000, 8'h00, 1'b1, 1'b1, 1, 1'b1); // undefined
    issue(4'b0010, 4'b0101, 4'b0011, 8'h06, 1'b0, 1'b0, 1, 1'b1); // xor
    issue(4'b0001, 4'b1100, 4'b1010, 8'h0E, 1'b0, 1'b0, 1, 1'b1); // or
    issue(4'b0011, 4'b0101, 4'b1111, 8'h0A, 1'b0, 1'b0, 1, 1'b1); // not
    issue(4'b0100, 4'b1100, 4'b1010, 8'h07, 1'b0, 1'b0, 1, 1'b1); // nand
    issue(4'b0101, 4'b1100, 4'b1010, 8'h01, 1'b0, 1'b0, 1, 1'b1); // nor
    issue(4'b0110, 4'b1100, 4'b1010, 8'h09, 1'b0, 1'b0, 1, 1'b1); // xnor
    issue(4'b1011, 4'b1001, 4'd1,    8'h0C, 1'b0, 1'b0, 3, 1'b1); // ror n=1
    issue(4'b1001, 4'b0100, 4'd1,    8'h02, 1'b0, 1'b0, 3, 1'b1); // sra positive
    issue(4'b1000, 4'b1111, 4'd15,   8'h00, 1'b1, 1'b0, 6, 1'b1); // sll sat
    issue(4'b1010, 4'b0110, 4'd3,    8'h03, 1'b0, 1'b0, 5, 1'b1); // rol n=3
    drain();

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    issue(4'b0001, 4'b0011, 4'b0101, 8'h07, 1'b0, 1'b0, 1, 1'b1);
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      sel = 4'(i); op1 = 4'($urandom); op2 = 4'($urandom);
      #2;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    repeat (4) @(negedge clk);

    // Reset while a shift is in EXEC: the command must vanish.
    issue(4'b1000, 4'b0001, 4'd3, 8'h08, 1'b0, 1'b0, 5, 1'b0);
    rst_n = 1'b0;
    @(negedge clk); #2;
    chk("exec_rst_out_valid", 32'(out_valid), 32'd0);
    chk("exec_rst_in_ready", 32'(in_ready), 32'd1);
    chk("exec_rst_l_out", 32'(l_out), 32'd0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);

    issue(4'b0010, 4'b1111, 4'b0001, 8'h0E, 1'b0, 1'b0, 1, 1'b1); // xor after reset
    drain();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/l_instr_seq.md
Name: l_instr_seq

Overview:
- Parametrised, handshaked successor of the 4-bit logic-instruction unit that feeds the LCD byte path.
- Executes bitwise ops in one cycle.
- Executes variable-amount shifts and rotates iteratively, one bit per clock.
- Holds each result, with zero/error flags, until the LCD-side consumer takes it.
- Sits between the operand/select mux and the LCD formatter.

Parameters:
- WIDTH, 4, operand width in bits (>=2).
- CNT_W, $clog2(WIDTH+1), width of the internal shift counter (derived; do not override).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  sel/op1/op2 are valid.
- in_ready  output  1  block can accept a command.
- sel  input  4  opcode.
- op1  input  WIDTH  first operand; data operand for shifts and rotates.
- op2  input  WIDTH  second operand; shift/rotate amount for shifts and rotates.
- out_valid  output  1  l_out and flags are valid.
- out_ready  input  1  consumer accepts the result.
- l_out  output  2*WIDTH  result, zero-extended: upper WIDTH bits always 0.
- zero  output  1  result == 0.
- err  output  1  sel was an undefined opcode.

Behaviour:
- Reset: rst_n sampled low at a clk edge forces:
  - state=IDLE, out_valid=0, l_out=0, zero=0, err=0, counter=0, working register=0.
  - Any in-flight command is discarded; no output is produced for it.
- States: IDLE, EXEC, HOLD.
- in_ready = (state==IDLE). It is purely a function of state, with no combinational path from in_valid or out_ready.
- Acceptance occurs when in_valid && in_ready at a clk edge. sel, op1 and op2 are latched at that edge; later input changes are ignored.
- Opcodes:
  - 0000 and; 0001 or; 0010 xor; 0011 not op1; 0100 nand; 0101 nor; 0110 xnor.
  - 0111 srl; 1000 sll; 1001 sra (msb replicated); 1010 rol; 1011 ror.
  - 1100-1111 undefined.
- Bitwise ops and undefined opcodes:
  - IDLE->HOLD at the acceptance edge, with result registered at that edge.
  - out_valid is high in the cycle after acceptance (latency 1).
  - An undefined opcode gives result=0, err=1.
- Shift/rotate amount n:
  - srl, sll, sra: n = min(op2, WIDTH). Saturation gives all-zero for srl/sll and all-sign for sra.
  - rol, ror: n = op2 mod WIDTH.
- Shift/rotate execution:
  - The acceptance edge loads the working register with op1 and the counter with n, and moves to EXEC.
  - In EXEC, at each edge: if counter==0, go to HOLD and register the result; otherwise shift/rotate by one bit and decrement the counter.
  - out_valid rises n+2 cycles after the acceptance edge; n=0 gives latency 2.
- HOLD:
  - out_valid=1; l_out, zero and err are stable.
  - On out_valid && out_ready at an edge: go to IDLE, out_valid=0. l_out and the flags keep their last values; they are only meaningful while out_valid=1.
  - While out_ready is low, HOLD persists indefinitely with no change.
- Back-to-back: at most one command is in flight. The next acceptance can happen no earlier than the cycle after the HOLD->IDLE edge, because in_ready is low in EXEC and HOLD.
- Flags:
  - zero = (result[WIDTH-1:0]==0), registered with l_out.
  - err is cleared by every defined opcode.
- Simultaneous events: rst_n low dominates in_valid and out_ready in the same cycle.
- in_valid asserted in EXEC or HOLD has no effect and is not queued.

Test Plan (WIDTH=4):
- Reset, then and with op1=1100, op2=1010, out_ready=1 -> out_valid in cycle 1 after accept; l_out=0x08, zero=0, err=0; in_ready back high the cycle after the handshake.
- sll with op1=0011, op2=2 -> out_valid 4 cycles after accept; l_out=0x0C. Then srl with op1=0011, op2=0 -> latency 2, l_out=0x03.
- sra with op1=1000, op2=9 (saturates to 4) -> latency 6, l_out=0x0F. Then srl with op1=1000, op2=7 -> l_out=0x00, zero=1.
- rol with op1=1001, op2=5 (n=1) -> l_out=0x03, latency 3. Then ror with op1=1001, op2=4 (n=0) -> l_out=0x09.
- sel=1110 with op1=1111 -> latency 1, l_out=0x00, err=1, zero=1. The next xor with op1=0101, op2=0011 -> l_out=0x06, err=0.
- Backpressure and reset:
  - Hold out_ready=0 for 3 cycles in HOLD while toggling in_valid and inputs -> l_out and flags constant, in_ready=0, no new accept.
  - Start sll with op2=3 and pull rst_n low during EXEC -> next cycle state IDLE, out_valid=0, l_out=0; no result is ever presented for that command.
